// File: rtl/layer2_pkg.sv
// Shared defaults and FSM encoding for the layer-2 bias-add and argmax block.
package layer2_pkg;

  localparam int OUT_SIZE_DEF = 10;
  localparam int W_DEF        = 8;
  localparam int ACC_W_DEF    = 24;
  localparam int IDX_W_DEF    = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_SCAN = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/layer2_argmax_cmp.sv
// One-neuron-per-cycle bias add and running-max tracker (strict greater, ties keep lowest index).
module layer2_argmax_cmp
  import layer2_pkg::*;
#(
  parameter int W     = W_DEF,
  parameter int ACC_W = ACC_W_DEF,
  parameter int IDX_W = IDX_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    first,
  input  logic [IDX_W-1:0]        idx,
  input  logic signed [ACC_W-1:0] acc,
  input  logic signed [W-1:0]     bias,
  output logic signed [ACC_W:0]   score,
  output logic signed [ACC_W:0]   max_score,
  output logic [IDX_W-1:0]        max_idx
);

  // One extra bit of headroom makes the sum of two sign-extended operands exact.
  assign score = {acc[ACC_W-1], acc} + {{(ACC_W + 1 - W){bias[W-1]}}, bias};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      max_score <= '0;
      max_idx   <= '0;
    end else if (en && (first || (score > max_score))) begin
      max_score <= score;
      max_idx   <= idx;
    end
  end

endmodule

// File: rtl/layer2_bias_argmax.sv
// Snapshots layer-2 MAC sums and biases, then scans them for the highest biased score.
// Optional macro LAYER2_SCORES_OUT_EN adds the scores_out port exposing every biased score.
module layer2_bias_argmax
  import layer2_pkg::*;
#(
  parameter int OUT_SIZE = OUT_SIZE_DEF,
  parameter int W        = W_DEF,
  parameter int ACC_W    = ACC_W_DEF,
  parameter int IDX_W    = IDX_W_DEF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [OUT_SIZE*W-1:0]     bias_in,
  input  logic                      bias_valid,
  input  logic [OUT_SIZE*ACC_W-1:0] acc_in,
  input  logic                      acc_valid,
  output logic [IDX_W-1:0]          class_out,
  output logic signed [ACC_W:0]     max_score,
  output logic                      busy,
  output logic                      done
`ifdef LAYER2_SCORES_OUT_EN
  ,
  output logic [OUT_SIZE*(ACC_W+1)-1:0] scores_out
`endif
);

  // The counter runs one step past the last neuron: that extra edge publishes the
  // registered running max, so done rises OUT_SIZE+1 edges after the snapshot edge.
  localparam int                CNT_W    = $clog2(OUT_SIZE + 1);
  localparam logic [CNT_W-1:0] SCAN_END = CNT_W'(OUT_SIZE);

  state_t                  state;
  logic [CNT_W-1:0]        idx;
  logic [IDX_W-1:0]        idx_sel;
  logic signed [W-1:0]     bias_q [OUT_SIZE];
  logic signed [ACC_W-1:0] acc_q  [OUT_SIZE];
  logic                    cmp_en;
  logic                    cmp_first;
  logic signed [ACC_W:0]   cmp_max;
  logic [IDX_W-1:0]        cmp_idx;
`ifdef LAYER2_SCORES_OUT_EN
  logic signed [ACC_W:0]   cmp_score;
`endif

  assign idx_sel   = idx[IDX_W-1:0];
  assign cmp_en    = (state == ST_SCAN) && (idx != SCAN_END);
  assign cmp_first = (idx == '0);

  layer2_argmax_cmp #(
    .W     (W),
    .ACC_W (ACC_W),
    .IDX_W (IDX_W)
  ) u_cmp (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (cmp_en),
    .first     (cmp_first),
    .idx       (idx_sel),
    .acc       (acc_q[idx_sel]),
    .bias      (bias_q[idx_sel]),
`ifdef LAYER2_SCORES_OUT_EN
    .score     (cmp_score),
`else
    .score     (),
`endif
    .max_score (cmp_max),
    .max_idx   (cmp_idx)
  );

  // NOTE: every update below is non-blocking, so all branches read pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      idx       <= '0;
      class_out <= '0;
      max_score <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      // NOTE: the snapshot array is reset too, so an aborted scan leaves no stale operands.
      for (int i = 0; i < OUT_SIZE; i++) begin
        bias_q[i] <= '0;
        acc_q[i]  <= '0;
      end
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state <= ST_WAIT;
            busy  <= 1'b1;
          end
        end
        ST_WAIT: begin
          if (bias_valid && acc_valid) begin
            for (int i = 0; i < OUT_SIZE; i++) begin
              bias_q[i] <= bias_in[i*W +: W];
              acc_q[i]  <= acc_in[i*ACC_W +: ACC_W];
            end
            idx   <= '0;
            state <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          if (idx == SCAN_END) begin
            class_out <= cmp_idx;
            max_score <= cmp_max;
            idx       <= '0;
            busy      <= 1'b0;
            done      <= 1'b1;
            state     <= ST_DONE;
          end else begin
            idx <= idx + CNT_W'(1);
          end
        end
        ST_DONE: begin
          if (start) begin
            done  <= 1'b0;
            busy  <= 1'b1;
            state <= ST_WAIT;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef LAYER2_SCORES_OUT_EN
  logic signed [ACC_W:0] scores_q [OUT_SIZE];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < OUT_SIZE; i++) scores_q[i] <= '0;
    end else if (cmp_en) begin
      scores_q[idx_sel] <= cmp_score;
    end
  end

  for (genvar g = 0; g < OUT_SIZE; g++) begin : g_scores
    assign scores_out[g*(ACC_W+1) +: ACC_W+1] = scores_q[g];
  end
`endif

endmodule

// File: tb/tb_layer2_bias_argmax.sv
// Self-checking bench for layer2_bias_argmax: directed corner cases plus randomized classifications.
module tb_layer2_bias_argmax;

  localparam int N  = 10;
  localparam int BW = 8;
  localparam int AW = 24;
  localparam int IW = 4;

  logic                clk        = 1'b0;
  logic                rst_n      = 1'b0;
  logic                start      = 1'b0;
  logic                bias_valid = 1'b0;
  logic                acc_valid  = 1'b0;
  logic [N*BW-1:0]     bias_in    = '0;
  logic [N*AW-1:0]     acc_in     = '0;
  logic [IW-1:0]       class_out;
  logic signed [AW:0]  max_score;
  logic                busy;
  logic                done;
`ifdef LAYER2_SCORES_OUT_EN
  logic [N*(AW+1)-1:0] scores_out;
`endif

  int     checks = 0;
  int     errors = 0;
  bit     chk_en = 1'b0;
  int     exp_class = 0;
  longint exp_score = 0;
  bit     exp_busy  = 1'b0;
  bit     exp_done  = 1'b0;
  longint exp_scores [N];
  longint mdl_scores [N];

  always #5 clk = ~clk;

  layer2_bias_argmax #(
    .OUT_SIZE (N),
    .W        (BW),
    .ACC_W    (AW),
    .IDX_W    (IW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .bias_in    (bias_in),
    .bias_valid (bias_valid),
    .acc_in     (acc_in),
    .acc_valid  (acc_valid),
    .class_out  (class_out),
    .max_score  (max_score),
    .busy       (busy),
    .done       (done)
`ifdef LAYER2_SCORES_OUT_EN
    ,
    .scores_out (scores_out)
`endif
  );

  task automatic check(input string name, input logic signed [63:0] act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: add each bias to its sum as plain integers, keep the first highest score.
  function automatic void model(input logic [N*AW-1:0] a, input logic [N*BW-1:0] b,
                                output int cls, output longint sc);
    cls = 0;
    for (int i = 0; i < N; i++) begin
      mdl_scores[i] = longint'($signed(a[i*AW +: AW])) + longint'($signed(b[i*BW +: BW]));
      if (i == 0 || mdl_scores[i] > sc) begin
        sc  = mdl_scores[i];
        cls = i;
      end
    end
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", busy, exp_busy);
      check("done", done, exp_done);
      check("class_out", class_out, exp_class);
      check("max_score", max_score, exp_score);
`ifdef LAYER2_SCORES_OUT_EN
      if (exp_done)
        for (int i = 0; i < N; i++)
          check("scores_out", $signed(scores_out[i*(AW+1) +: AW+1]), exp_scores[i]);
`endif
    end
  end

  task automatic scramble(input bit allow_start);
    for (int i = 0; i < N; i++) begin
      acc_in[i*AW +: AW]  = AW'($urandom);
      bias_in[i*BW +: BW] = BW'($urandom);
    end
    acc_valid  = 1'($urandom % 2);
    bias_valid = 1'($urandom % 2);
    start      = allow_start ? 1'($urandom % 2) : 1'b0;
  endtask

  // One classification: start, optional bias_valid delay, scan with garbage inputs,
  // optional reset asserted while the scan sits at index rst_at.
  task automatic run(input logic [N*AW-1:0] a, input logic [N*BW-1:0] b,
                     input int delay, input int rst_at);
    int     cls;
    longint sc;
    int     lat;
    bit     aborted;
    model(a, b, cls, sc);
    lat     = 0;
    aborted = 1'b0;
    @(negedge clk);
    start      = 1'b1;
    acc_in     = a;
    bias_in    = b;
    acc_valid  = 1'b1;
    bias_valid = (delay == 0);
    @(posedge clk);
    #1 exp_busy = 1'b1;
    exp_done = 1'b0;
    for (int d = 0; d < delay; d++) begin
      @(negedge clk);
      start      = 1'($urandom % 2);
      bias_valid = 1'b0;
    end
    @(negedge clk);
    start      = 1'($urandom % 2);
    acc_in     = a;
    bias_in    = b;
    acc_valid  = 1'b1;
    bias_valid = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= N + 1 && !aborted; k++) begin
      @(negedge clk);
      scramble(k < N + 1);
      if (rst_at >= 0 && k == rst_at + 1) rst_n = 1'b0;
      @(posedge clk);
      #1;
      if (!rst_n) begin
        aborted   = 1'b1;
        exp_busy  = 1'b0;
        exp_done  = 1'b0;
        exp_class = 0;
        exp_score = 0;
      end else begin
        if (done && lat == 0) lat = k;
        if (k == N + 1) begin
          exp_busy  = 1'b0;
          exp_done  = 1'b1;
          exp_class = cls;
          exp_score = sc;
          for (int i = 0; i < N; i++) exp_scores[i] = mdl_scores[i];
        end
      end
    end
    @(negedge clk);
    rst_n      = 1'b1;
    start      = 1'b0;
    acc_valid  = 1'b0;
    bias_valid = 1'b0;
    if (!aborted) check("done_latency", lat, N + 1);
  endtask

  logic [N*AW-1:0] av;
  logic [N*BW-1:0] bv;

  initial begin
    for (int i = 0; i < N; i++) exp_scores[i] = 0;
    repeat (3) @(posedge clk);
    #1 chk_en = 1'b1;
    check("reset_class", class_out, 0);
    check("reset_score", max_score, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Accumulators zero, biases ramp 0..9; start coincides with both valids.
    for (int i = 0; i < N; i++) begin
      av[i*AW +: AW] = '0;
      bv[i*BW +: BW] = BW'(i);
    end
    run(av, bv, 0, -1);
    check("ramp_class", class_out, 9);
    check("ramp_score", max_score, 9);

    // Big sum with most negative bias still beats a max positive bias.
    av = '0;
    bv = '0;
    av[3*AW +: AW] = AW'(1000);
    bv[3*BW +: BW] = 8'h80;
    bv[7*BW +: BW] = 8'h7f;
    run(av, bv, 0, -1);
    check("neg_bias_class", class_out, 3);
    check("neg_bias_score", max_score, 872);

    // Every score equals 5: the lowest index wins.
    for (int i = 0; i < N; i++) begin
      bv[i*BW +: BW] = BW'(i - 3);
      av[i*AW +: AW] = AW'(5 - (i - 3));
    end
    run(av, bv, 1, -1);
    check("tie_class", class_out, 0);
    check("tie_score", max_score, 5);

    // Most negative operands everywhere: the score needs the extra bit.
    for (int i = 0; i < N; i++) begin
      av[i*AW +: AW] = 24'h800000;
      bv[i*BW +: BW] = 8'h80;
    end
    run(av, bv, 0, -1);
    check("min_class", class_out, 0);
    check("min_score", max_score, -8388736);

    // bias_valid arrives 20 cycles late; inputs are garbage during the scan.
    for (int i = 0; i < N; i++) begin
      av[i*AW +: AW] = AW'(int'($urandom_range(0, 2000)) - 1000);
      bv[i*BW +: BW] = BW'($urandom);
    end
    run(av, bv, 20, -1);

    // Reset while the scan sits at index 5, then a clean classification.
    run(av, bv, 0, 5);
    check("abort_class", class_out, 0);
    check("abort_score", max_score, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    run(av, bv, 2, -1);

    for (int r = 0; r < 30; r++) begin
      for (int i = 0; i < N; i++) begin
        if (r % 3 == 0) av[i*AW +: AW] = AW'($urandom);
        else            av[i*AW +: AW] = AW'(int'($urandom_range(0, 40)) - 20);
        if (r % 3 == 1) bv[i*BW +: BW] = BW'(int'($urandom_range(0, 6)) - 3);
        else            bv[i*BW +: BW] = BW'($urandom);
      end
      run(av, bv, int'($urandom_range(0, 3)), -1);
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/layer2_bias_argmax.md
LAYER2_BIAS_ARGMAX -- requirements
Module: layer2_bias_argmax

Interface
REQ-001 SHALL have parameter OUT_SIZE, default 10, number of layer-2 neurons/classes.
REQ-002 SHALL have parameter W, default 8, signed bias width.
REQ-003 SHALL have parameter ACC_W, default 24, signed accumulator width.
REQ-004 SHALL have parameter IDX_W, default 4, class index width (ceil log2 OUT_SIZE).
REQ-005 SHALL have port clk  input  1  system clock; single clock domain.
REQ-006 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-007 SHALL have port start  input  1  single-cycle request to classify.
REQ-008 SHALL have port bias_in  input  OUT_SIZE*W  flattened biases; neuron i at [i*W +: W].
REQ-009 SHALL have port bias_valid  input  1  level, high when bias_in is complete (bias loader done).
REQ-010 SHALL have port acc_in  input  OUT_SIZE*ACC_W  flattened MAC sums; neuron i at [i*ACC_W +: ACC_W].
REQ-011 SHALL have port acc_valid  input  1  level, high when acc_in is complete.
REQ-012 SHALL have port class_out  output  IDX_W  winning class index.
REQ-013 SHALL have port max_score  output  ACC_W+1  winning biased score, signed.
REQ-014 SHALL have port busy  output  1  high in WAIT and SCAN.
REQ-015 SHALL have port done  output  1  high in DONE state.

Function
REQ-016 SHALL implement FSM states IDLE, WAIT, SCAN, DONE.
REQ-017 IDLE: start=1 -> WAIT; start ignored in WAIT and SCAN.
REQ-018 WAIT: on first cycle with bias_valid=1 and acc_valid=1, snapshot both vectors into internal registers, index=0 -> SCAN; inputs are not used after the snapshot.
REQ-019 SCAN: one neuron per cycle; score_i = sign-extend(acc_i to ACC_W+1) + sign-extend(bias_i to ACC_W+1); no overflow is possible.
REQ-020 Index 0 SHALL load running max unconditionally; later index replaces max only if score strictly greater (ties keep lowest index).
REQ-021 After index OUT_SIZE-1 is evaluated -> DONE; done SHALL assert exactly OUT_SIZE+1 cycles after the snapshot cycle.
REQ-022 class_out/max_score SHALL update only on DONE entry and hold until the next DONE entry or reset.
REQ-023 DONE: done held high; start=1 -> WAIT (done drops next cycle, outputs hold old result); otherwise stay.
REQ-024 start in IDLE coinciding with both valids high SHALL still pass through WAIT (snapshot one cycle later).

Reset
REQ-025 rst_n=0 at a clock edge SHALL force IDLE, class_out=0, max_score=0, busy=0, done=0, index=0, snapshot registers=0, including mid-SCAN; no partial result is published.

Configuration
REQ-026 With macro LAYER2_SCORES_OUT_EN defined, SHALL add output scores_out (OUT_SIZE*(ACC_W+1)) holding each score_i written during SCAN, valid while done=1, reset to 0; without it, port and storage SHALL be absent and all other behaviour identical.

Structure
REQ-027 Package layer2_pkg SHALL hold OUT_SIZE, W, ACC_W, IDX_W defaults and FSM state encoding.
REQ-028 Sub-module layer2_argmax_cmp SHALL perform the signed add and strict-greater compare/update of one neuron per cycle.

Verification
REQ-029 acc all 0, bias = {0,1,2,...,9} -> class_out=9, max_score=9, done 11 cycles after snapshot.
REQ-030 acc_3=1000, others 0, bias_3=-128 (0x80), bias_7=127 -> class_out=3, max_score=872.
REQ-031 All scores equal 5 -> class_out=0 (tie rule), max_score=5.
REQ-032 Max-negative: acc all 0x800000, bias all 0x80 -> max_score=-8388736, class_out=0, no wrap.
REQ-033 start, acc_valid high, bias_valid delayed 20 cycles -> stays WAIT with busy=1, snapshot on bias_valid cycle; then inputs changed during SCAN -> result unaffected.
REQ-034 rst_n low at SCAN index 5 -> next cycle IDLE, all outputs 0; new start completes normally.
